// File: rtl/whack_pkg.sv
// Shared types and helpers for the whack-a-mole game blocks.
// Holds the scheduler state encoding and the level-to-show-time rule.
package whack_pkg;

    localparam int HOLE_W  = 4;
    localparam int LEVEL_W = 2;
    localparam int TICK_W  = 5;
    localparam int CNT_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        GAP,
        SHOW,
        RESOLVE
    } sched_state_t;

    // Show time shrinks with level but never drops below one tick.
    function automatic logic [TICK_W-1:0] show_ticks(
        input logic [LEVEL_W-1:0] level,
        input int                 l0,
        input int                 step
    );
        int v;
        v = l0 - step * int'(level);
        if (v < 1) v = 1;
        return v[TICK_W-1:0];
    endfunction

endpackage

// File: rtl/lfsr16.sv
// Free-running 16-bit Fibonacci LFSR, taps 16,14,13,11.
// Shared by any block needing cheap pseudo-random bits.
module lfsr16 #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst,
    output logic [15:0] state
);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= SEED;
        end else begin
            state <= {state[14:0],
                      state[15] ^ state[13] ^ state[12] ^ state[10]};
        end
    end

endmodule

// File: rtl/mole_scheduler.sv
// Sequences one round of moles: gap, show, judge hits, resolve.
// All pulse outputs are registered one cycle after the deciding edge.
module mole_scheduler
    import whack_pkg::*;
#(
    parameter int          TICK_DIV        = 2_500_000,
    parameter int          SHOW_L0         = 12,
    parameter int          SHOW_STEP       = 3,
    parameter int          GAP_TICKS       = 4,
    parameter int          MOLES_PER_ROUND = 8,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               game_start,
    input  logic               game_over,
    input  logic [LEVEL_W-1:0] round_level,
    input  logic               hit,
    input  logic [HOLE_W-1:0]  hit_index,
    output logic               mole_appear,
    output logic [HOLE_W-1:0]  mole_index,
    output logic               hit_success,
    output logic               wrong_hit,
    output logic               miss,
    output logic               round_done,
    output logic               busy
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    sched_state_t      state, state_n;
    logic              start_q, hit_q;
    logic [PW-1:0]     presc;
    logic [TICK_W-1:0] ticks, show_len;
    logic [CNT_W-1:0]  mole_cnt;
    logic [15:0]       lfsr;
    logic              unused_lfsr;

    logic start_rise, hit_rise, tick;
    logic gap_done, show_done, hit_ok, last;
    logic [HOLE_W-1:0] cand, next_index;
    logic appear_n, hit_n, wrong_n, miss_n, done_n;

    lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
        .clk   (clk),
        .rst   (rst),
        .state (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:4];

    assign start_rise = game_start & ~start_q;
    assign hit_rise   = hit & ~hit_q;
    assign tick       = (presc == PW'(TICK_DIV - 1));
    assign gap_done   = tick && (ticks == TICK_W'(GAP_TICKS - 1));
    assign show_done  = tick && (ticks == show_len - 1'b1);
    assign hit_ok     = hit_rise && (hit_index == mole_index);
    assign last       = (mole_cnt == CNT_W'(MOLES_PER_ROUND - 1));
    assign cand       = lfsr[HOLE_W-1:0];
    // Never show the same hole twice in a row.
    assign next_index = (cand == mole_index) ? cand + 1'b1 : cand;
    assign busy       = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            mole_appear <= 1'b0;
            hit_success <= 1'b0;
            wrong_hit   <= 1'b0;
            miss        <= 1'b0;
            round_done  <= 1'b0;
        end else begin
            state       <= state_n;
            mole_appear <= appear_n;
            hit_success <= hit_n;
            wrong_hit   <= wrong_n;
            miss        <= miss_n;
            round_done  <= done_n;
        end
    end

    always_comb begin
        state_n = state;
        if (game_over) begin
            state_n = IDLE;
        end else begin
            unique case (state)
                IDLE:    if (start_rise) state_n = GAP;
                GAP:     if (gap_done) state_n = SHOW;
                SHOW:    if (hit_ok || show_done) state_n = RESOLVE;
                RESOLVE: state_n = last ? IDLE : GAP;
                default: state_n = IDLE;
            endcase
        end
    end

    // A correct hit wins over expiry; expiry wins over a wrong hit.
    always_comb begin
        appear_n = (state_n == SHOW);
        hit_n    = 1'b0;
        wrong_n  = 1'b0;
        miss_n   = 1'b0;
        done_n   = 1'b0;
        if (!game_over) begin
            unique case (1'b1)
                state == SHOW: begin
                    if (hit_ok)         hit_n   = 1'b1;
                    else if (show_done) miss_n  = 1'b1;
                    else if (hit_rise)  wrong_n = 1'b1;
                end
                state == RESOLVE: done_n = last;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            start_q    <= 1'b0;
            hit_q      <= 1'b0;
            presc      <= '0;
            ticks      <= '0;
            mole_cnt   <= '0;
            mole_index <= '0;
            show_len   <= '0;
        end else begin
            start_q <= game_start;
            hit_q   <= hit;
            if (state_n != state) begin
                presc <= '0;
                ticks <= '0;
            end else if (tick) begin
                presc <= '0;
                ticks <= ticks + 1'b1;
            end else begin
                presc <= presc + 1'b1;
            end
            if (state == IDLE && state_n == GAP) begin
                mole_cnt <= '0;
            end else if (state == RESOLVE && !game_over) begin
                mole_cnt <= mole_cnt + 1'b1;
            end
            if (state == GAP && state_n == SHOW) begin
                mole_index <= next_index;
                show_len   <= show_ticks(round_level, SHOW_L0, SHOW_STEP);
            end
        end
    end

endmodule

// File: tb/tb_mole_scheduler.sv
// Self-checking bench for mole_scheduler with a cycle-countdown model.
// Directed scenarios plus randomized play, all compared every cycle.
module tb_mole_scheduler;

    localparam int TD   = 4;
    localparam int L0   = 12;
    localparam int STP  = 3;
    localparam int GAPT = 4;
    localparam int MPR  = 3;
    localparam logic [15:0] SEED = 16'hACE1;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       gs = 1'b0, go = 1'b0, h = 1'b0;
    logic [1:0] lvl = 2'd0;
    logic [3:0] hi = 4'd0;

    logic       mole_appear, hit_success, wrong_hit, miss, round_done, busy;
    logic [3:0] mole_index;

    int vecs = 0;
    int errs = 0;

    // Model: mode 0 idle, 1 waiting, 2 mole up, 3 resolving.
    logic [15:0] m_lfsr;
    logic [3:0]  m_idx;
    int          mode, left, cnt;
    logic        p_start, p_hit;
    logic        e_appear, e_hit, e_wrong, e_miss, e_done;

    logic [9:0] obs, exp_v;
    assign obs = {mole_appear, mole_index, hit_success, wrong_hit,
                  miss, round_done, busy};
    assign exp_v = {e_appear, m_idx, e_hit, e_wrong,
                    e_miss, e_done, (mode != 0)};

    always #5 clk = ~clk;

    mole_scheduler #(
        .TICK_DIV        (TD),
        .SHOW_L0         (L0),
        .SHOW_STEP       (STP),
        .GAP_TICKS       (GAPT),
        .MOLES_PER_ROUND (MPR),
        .LFSR_SEED       (SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .game_start  (gs),
        .game_over   (go),
        .round_level (lvl),
        .hit         (h),
        .hit_index   (hi),
        .mole_appear (mole_appear),
        .mole_index  (mole_index),
        .hit_success (hit_success),
        .wrong_hit   (wrong_hit),
        .miss        (miss),
        .round_done  (round_done),
        .busy        (busy)
    );

    task automatic model_reset();
        m_lfsr = SEED; m_idx = 4'd0; mode = 0; left = 0; cnt = 0;
        p_start = 1'b0; p_hit = 1'b0;
        e_appear = 1'b0; e_hit = 1'b0; e_wrong = 1'b0;
        e_miss = 1'b0; e_done = 1'b0;
    endtask

    task automatic model_step();
        logic srise, hrise;
        logic [3:0] c;
        int ln, lv;
        srise = gs && !p_start;
        hrise = h && !p_hit;
        e_hit = 1'b0; e_wrong = 1'b0; e_miss = 1'b0; e_done = 1'b0;
        if (go) begin
            mode = 0; e_appear = 1'b0;
        end else begin
            case (mode)
                0: if (srise) begin
                    mode = 1; left = GAPT * TD; cnt = 0;
                end
                1: begin
                    left--;
                    if (left == 0) begin
                        c = m_lfsr[3:0];
                        if (c == m_idx) c = c + 4'd1;
                        m_idx = c;
                        lv = int'(lvl);
                        ln = L0 - STP * lv;
                        if (ln < 1) ln = 1;
                        left = ln * TD; mode = 2; e_appear = 1'b1;
                    end
                end
                2: begin
                    left--;
                    if (hrise && hi == m_idx) begin
                        e_hit = 1'b1; mode = 3; e_appear = 1'b0;
                    end else if (left == 0) begin
                        e_miss = 1'b1; mode = 3; e_appear = 1'b0;
                    end else if (hrise) begin
                        e_wrong = 1'b1;
                    end
                end
                default: begin
                    cnt++;
                    if (cnt == MPR) begin
                        e_done = 1'b1; mode = 0;
                    end else begin
                        mode = 1; left = GAPT * TD;
                    end
                end
            endcase
        end
        p_start = gs; p_hit = h;
        m_lfsr = {m_lfsr[14:0],
                  m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    endtask

    task automatic step();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b0; gs = 1'b0; go = 1'b0; h = 1'b0; hi = 4'd0; lvl = 2'd0;
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
    endtask

    task automatic sync_idle();
        gs = 1'b0; h = 1'b0; go = 1'b1;
        step();
        go = 1'b0;
        step();
    endtask

    task automatic test_reset();
        rst = 1'b0; gs = 1'b0; go = 1'b0; h = 1'b0; hi = 4'd0; lvl = 2'd0;
        model_reset();
        #1;
        vecs++;
        if (obs !== 10'd0) begin
            errs++; $display("FAIL reset_async dut=%h want=000", obs);
        end
        @(posedge clk);
        #1;
        vecs++;
        if (obs !== exp_v) begin
            errs++; $display("FAIL reset_hold dut=%h model=%h", obs, exp_v);
        end
        rst = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL reset_idle dut=%h model=%h", obs, exp_v);
            end
        end
    endtask

    task automatic test_timeout();
        int t, first_app, app_len, misses;
        bit seen_done;
        sync_idle();
        lvl = 2'd0; gs = 1'b1;
        t = 0; first_app = -1; app_len = 0; misses = 0; seen_done = 0;
        for (int k = 0; k < 400 && !seen_done; k++) begin
            step(); vecs++; t++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL timeout_cyc dut=%h model=%h", obs, exp_v);
            end
            if (mole_appear && first_app < 0) first_app = t;
            if (mole_appear && misses == 0) app_len++;
            if (miss) misses++;
            if (round_done) seen_done = 1;
        end
        vecs++;
        if (first_app != GAPT * TD + 1) begin
            errs++; $display("FAIL timeout_first dut=%0d want=%0d", first_app, GAPT * TD + 1);
        end
        vecs++;
        if (app_len != L0 * TD) begin
            errs++; $display("FAIL timeout_len dut=%0d want=%0d", app_len, L0 * TD);
        end
        vecs++;
        if (misses != MPR || !seen_done || busy !== 1'b0) begin
            errs++; $display("FAIL timeout_round miss=%0d done=%0d busy=%b want %0d/1/0",
                             misses, seen_done, busy, MPR);
        end
        gs = 1'b0;
    endtask

    task automatic test_correct_hit();
        int gapn;
        sync_idle();
        lvl = 2'd2; gs = 1'b1;
        for (int k = 0; k < 40 && !mole_appear; k++) begin
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL hit_wait dut=%h model=%h", obs, exp_v);
            end
        end
        vecs++;
        if (mole_appear !== 1'b1) begin
            errs++; $display("FAIL hit_appear dut=%b want=1", mole_appear);
        end
        for (int k = 0; k < 10; k++) begin
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL hit_mid dut=%h model=%h", obs, exp_v);
            end
        end
        hi = m_idx; h = 1'b1;
        step(); vecs++;
        if (hit_success !== 1'b1 || mole_appear !== 1'b0) begin
            errs++; $display("FAIL hit_pulse hit=%b appear=%b want 1/0", hit_success, mole_appear);
        end
        step(); vecs++;
        if (hit_success !== 1'b0) begin
            errs++; $display("FAIL hit_single dut=%b want=0", hit_success);
        end
        gapn = 1;
        for (int k = 0; k < 40 && !mole_appear; k++) begin
            step(); vecs++; gapn++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL hit_gap dut=%h model=%h", obs, exp_v);
            end
        end
        vecs++;
        if (gapn != GAPT * TD + 1) begin
            errs++; $display("FAIL hit_next dut=%0d want=%0d", gapn, GAPT * TD + 1);
        end
        for (int k = 0; k < 6; k++) begin
            step(); vecs++;
            if (obs !== exp_v || hit_success !== 1'b0) begin
                errs++; $display("FAIL hit_held dut=%h model=%h", obs, exp_v);
            end
        end
        h = 1'b0; gs = 1'b0;
    endtask

    task automatic test_wrong_then_expiry();
        int len;
        bit saw_miss;
        sync_idle();
        lvl = 2'd2; gs = 1'b1;
        for (int k = 0; k < 40 && !mole_appear; k++) begin
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL wrong_wait dut=%h model=%h", obs, exp_v);
            end
        end
        len = 0; saw_miss = 0;
        for (int k = 0; k < 60 && mole_appear; k++) begin
            len++;
            if (len == 5) begin
                hi = m_idx + 4'd1; h = 1'b1;
            end
            if (len == 6) h = 1'b0;
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL wrong_cyc dut=%h model=%h", obs, exp_v);
            end
            if (len == 5) begin
                vecs++;
                if (wrong_hit !== 1'b1 || mole_appear !== 1'b1) begin
                    errs++; $display("FAIL wrong_pulse wrong=%b appear=%b want 1/1",
                                     wrong_hit, mole_appear);
                end
            end
            if (miss) saw_miss = 1;
        end
        vecs++;
        if (len != 24 || !saw_miss) begin
            errs++; $display("FAIL wrong_len2 dut=%0d miss=%0d want 24/1", len, saw_miss);
        end
        lvl = 2'd3;
        for (int k = 0; k < 40 && !mole_appear; k++) begin
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL wrong_wait3 dut=%h model=%h", obs, exp_v);
            end
        end
        len = 0;
        for (int k = 0; k < 60 && mole_appear; k++) begin
            len++;
            if (len == 3) lvl = 2'd0;
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL wrong_cyc3 dut=%h model=%h", obs, exp_v);
            end
        end
        vecs++;
        if (len != 12) begin
            errs++; $display("FAIL wrong_len3 dut=%0d want=12", len);
        end
        gs = 1'b0;
    endtask

    task automatic test_expiry_hit();
        int len;
        bit got, missed;
        sync_idle();
        lvl = 2'd3; gs = 1'b1;
        for (int k = 0; k < 40 && !mole_appear; k++) begin
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL exp_wait dut=%h model=%h", obs, exp_v);
            end
        end
        len = 0; got = 0; missed = 0;
        for (int k = 0; k < 40 && mole_appear; k++) begin
            len++;
            if (len == 12) begin
                hi = m_idx; h = 1'b1;
            end
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL exp_cyc dut=%h model=%h", obs, exp_v);
            end
            if (hit_success) got = 1;
            if (miss) missed = 1;
        end
        vecs++;
        if (!got || missed || len != 12) begin
            errs++; $display("FAIL exp_hit hit=%0d miss=%0d len=%0d want 1/0/12",
                             got, missed, len);
        end
        h = 1'b0; gs = 1'b0;
    endtask

    task automatic test_abort();
        int misses;
        bit seen_done;
        sync_idle();
        lvl = 2'd1; gs = 1'b1;
        for (int k = 0; k < 40 && !mole_appear; k++) begin
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL abort_wait dut=%h model=%h", obs, exp_v);
            end
        end
        for (int k = 0; k < 5; k++) step();
        go = 1'b1; hi = mole_index; h = 1'b1;
        step(); vecs++;
        if (obs !== {1'b0, m_idx, 5'b0}) begin
            errs++; $display("FAIL abort_idle dut=%h want=%h", obs, {1'b0, m_idx, 5'b0});
        end
        go = 1'b0; gs = 1'b0; h = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL abort_quiet dut=%h model=%h", obs, exp_v);
            end
        end
        gs = 1'b1; misses = 0; seen_done = 0;
        for (int k = 0; k < 400 && !seen_done; k++) begin
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL abort_run dut=%h model=%h", obs, exp_v);
            end
            if (miss) misses++;
            if (round_done) seen_done = 1;
        end
        vecs++;
        if (misses != MPR || !seen_done) begin
            errs++; $display("FAIL abort_restart miss=%0d done=%0d want %0d/1",
                             misses, seen_done, MPR);
        end
        gs = 1'b0;
    endtask

    task automatic test_reset_mid_show();
        sync_idle();
        lvl = 2'd0; gs = 1'b1;
        for (int k = 0; k < 40 && !mole_appear; k++) step();
        for (int k = 0; k < 3; k++) step();
        gs = 1'b0;
        #2;
        rst = 1'b0;
        model_reset();
        #1;
        vecs++;
        if (obs !== 10'd0) begin
            errs++; $display("FAIL reset_mid dut=%h want=000", obs);
        end
        #2;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL reset_after dut=%h model=%h", obs, exp_v);
            end
        end
    endtask

    task automatic test_seed_repeat();
        logic [3:0] seq [2][3];
        int n;
        bit done;
        logic prev;
        for (int p = 0; p < 2; p++) begin
            do_reset();
            gs = 1'b1; n = 0; done = 0;
            for (int k = 0; k < 400 && !done; k++) begin
                prev = mole_appear;
                step(); vecs++;
                if (obs !== exp_v) begin
                    errs++; $display("FAIL seed_cyc dut=%h model=%h", obs, exp_v);
                end
                if (mole_appear && !prev && n < 3) begin
                    seq[p][n] = mole_index; n++;
                end
                if (round_done) done = 1;
            end
            vecs++;
            if (n != 3 || !done) begin
                errs++; $display("FAIL seed_round moles=%0d done=%0d want 3/1", n, done);
            end
            gs = 1'b0;
        end
        for (int i = 0; i < 3; i++) begin
            vecs++;
            if (seq[1][i] !== seq[0][i]) begin
                errs++; $display("FAIL seed_idx%0d dut=%h want=%h", i, seq[1][i], seq[0][i]);
            end
        end
    endtask

    task automatic test_random();
        logic [3:0] last;
        logic prev;
        do_reset();
        last = 4'd0;
        for (int k = 0; k < 3000; k++) begin
            if ($urandom_range(0, 19) == 0) gs = ~gs;
            go = ($urandom_range(0, 299) == 0);
            lvl = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 5) == 0) h = ~h;
            if ($urandom_range(0, 1) == 0) hi = m_idx;
            else hi = 4'($urandom_range(0, 15));
            prev = mole_appear;
            step(); vecs++;
            if (obs !== exp_v) begin
                errs++; $display("FAIL rand_cyc dut=%h model=%h", obs, exp_v);
            end
            if (mole_appear && !prev) begin
                vecs++;
                if (mole_index === last) begin
                    errs++; $display("FAIL rand_repeat dut=%h prev=%h want differ",
                                     mole_index, last);
                end
                last = mole_index;
            end
        end
        gs = 1'b0; go = 1'b0; h = 1'b0;
    endtask

    initial begin
        test_reset();
        test_timeout();
        test_correct_hit();
        test_wrong_then_expiry();
        test_expiry_hit();
        test_abort();
        test_reset_mid_show();
        test_seed_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/mole_scheduler.md
Name: mole_scheduler

Overview:
- Sequences mole appearances for one round of the whack-a-mole game.
- Picks a pseudo-random hole (0..15) for each mole and holds it visible for a level-dependent time.
- Judges player hits against the visible mole and reports hit, miss and round completion to the game controller and score logic.
- Drives the mole_appear/mole_index pair consumed by the mole renderer.

Parameters:
- TICK_DIV, 2_500_000: clk cycles per timing tick (0.1 s at 25 MHz).
- SHOW_L0, 12: show time in ticks at level 0. Each level subtracts SHOW_STEP.
- SHOW_STEP, 3: ticks removed per level.
- GAP_TICKS, 4: ticks with no mole between appearances.
- MOLES_PER_ROUND, 8: moles presented per round.
- LFSR_SEED, 16'hACE1: LFSR reset value; must be nonzero.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- game_start  in  1  level; its rising edge starts a round
- game_over  in  1  level; forces abort to IDLE
- round_level  in  2  current level 0..3; sampled at each mole launch
- hit  in  1  key-enable level; its rising edge is one hit attempt
- hit_index  in  4  hole struck; valid when hit is high
- mole_appear  out  1  a mole is visible
- mole_index  out  4  hole of the visible mole
- hit_success  out  1  1-cycle pulse: correct hole struck
- wrong_hit  out  1  1-cycle pulse: a hit struck a non-mole hole while SHOW
- miss  out  1  1-cycle pulse: mole expired unhit
- round_done  out  1  1-cycle pulse: last mole of the round resolved
- busy  out  1  state is not IDLE

Behaviour:
- Reset (rst low, async): state IDLE, every output 0, LFSR = LFSR_SEED, mole counter 0, prescaler 0, edge-detect registers 0.
- Edge detect: game_start and hit are registered once; a rise is current=1 with previous=0. There is no further synchroniser.
- Prescaler: counts 0..TICK_DIV-1 and issues a tick at TICK_DIV-1. It clears on every state entry, so a state lasting N ticks lasts exactly N*TICK_DIV cycles.
- LFSR: 16-bit Fibonacci, taps 16,14,13,11. It advances every clk in every state.
- States:
  - IDLE: a game_start rise goes to GAP, clears the mole counter and the prescaler. game_start rises while not IDLE are ignored.
  - GAP: after GAP_TICKS ticks, launch. Candidate index = LFSR[3:0]. If the candidate equals the previous mole_index, use candidate+1 mod 16. Latch show_ticks = SHOW_L0 - SHOW_STEP*round_level. If that result is < 1, use 1. Go to SHOW with mole_appear=1 on the first SHOW cycle. Hits in GAP are ignored with no pulse.
  - SHOW:
    - Hit rise with hit_index==mole_index: hit_success pulses in the next cycle, mole_appear drops in that same cycle, go to RESOLVE.
    - Hit rise with a different index: wrong_hit pulses and the mole stays.
    - show_ticks ticks elapsed with no hit: miss pulses, mole_appear drops, go to RESOLVE.
    - A correct hit in the same cycle as the expiry tick counts as hit_success, not miss.
  - RESOLVE (1 cycle): increment the mole counter. If it equals MOLES_PER_ROUND, pulse round_done and go to IDLE. Otherwise go to GAP.
- mole_index holds its last value after mole_appear drops; downstream gates it with mole_appear.
- game_over high in any state: go to IDLE next cycle, mole_appear=0. No hit_success, miss or round_done pulse is issued. game_over has priority over a same-cycle hit.
- round_level changes during SHOW do not affect the current mole.
- Counters: mole counter is 8 bits; the show/gap tick counter is 5 bits. MOLES_PER_ROUND must be ≤255.
- At most one of hit_success, wrong_hit and miss is high in any cycle.

Decomposition:
- Shared package whack_pkg holds:
  - sched_state_t enum: IDLE, GAP, SHOW, RESOLVE.
  - Width constants: HOLE_W=4, LEVEL_W=2.
  - A show_ticks(level) function implementing the saturating formula.
- One sub-module, lfsr16: seed parameter, advance every cycle, 16-bit state output. It is reusable by other random effects.

Test Plan:
All scenarios use TICK_DIV=4, SHOW_L0=12, SHOW_STEP=3, GAP_TICKS=4, MOLES_PER_ROUND=3.
- Timeout: start rise at level 0, no hits -> mole_appear rises 16 cycles after entering GAP and stays 48 cycles. Miss pulses once. After 3 moles, round_done pulses and busy=0.
- Correct hit: level 2, hit rise with hit_index=mole_index mid-SHOW -> hit_success for exactly 1 cycle and mole_appear=0 in that cycle. The next mole appears 16 cycles after RESOLVE. A held hit level produces no second hit.
- Wrong hit then expiry: wrong index mid-SHOW -> wrong_hit pulse, mole stays, then miss at expiry. SHOW lasts 24 cycles at level 2 and 12 cycles at level 3.
- Hit on expiry cycle: correct hit rise on the final SHOW tick -> hit_success=1, miss never asserts.
- Abort: game_over asserted during SHOW -> IDLE next cycle, mole_appear=0, no pulses. A later start restarts with the mole counter at 0.
- Reset mid-SHOW and index rule: rst low asynchronously -> all outputs 0 immediately. Across a full run, consecutive mole_index values never repeat. The same seed reproduces the same index sequence.
